// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline-stage register
// Skid FSM encoding, control-bit positions and EX/MEM payload field layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam int CTRL_MEMREAD  = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 4;

  // EX/MEM payload packed LSB-first: zeroFlag, writeReg, readData2, ALUResult, branchTarget
  localparam int EXMEM_DATA_W            = 198;
  localparam int EXMEM_ZERO_FLAG_LSB     = 0;
  localparam int EXMEM_WRITE_REG_LSB     = 1;
  localparam int EXMEM_READ_DATA2_LSB    = 6;
  localparam int EXMEM_ALU_RESULT_LSB    = 70;
  localparam int EXMEM_BRANCH_TARGET_LSB = 134;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - skid entry and EMPTY/ONE/FULL occupancy FSM
// Present only when PIPE_SKID_EN is defined; steers loads of the main register in the parent.
`ifdef PIPE_SKID_EN
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 200,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              rdy,
  output logic              main_ld_in,
  output logic              main_ld_skid,
  output logic [DATA_W-1:0] skid_data,
  output logic [CTRL_W-1:0] skid_ctrl,
  output logic [1:0]        occupancy
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [CTRL_W-1:0] sctrl_q, sctrl_d;
  logic              rdy_q, rdy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      sdata_q <= '0;
      sctrl_q <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sdata_q <= sdata_d;
      sctrl_q <= sctrl_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sdata_d      = sdata_q;
    sctrl_d      = sctrl_q;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
      sctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          state_d    = ONE;
          main_ld_in = 1'b1;
        end
        ONE: begin
          if (push && !pop) begin
            state_d = FULL;
            sdata_d = in_data;
            sctrl_d = in_ctrl;
          end else if (push && pop) begin
            main_ld_in = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: if (pop) begin
          state_d      = ONE;
          main_ld_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
    // Ready is registered from the next state so upstream never sees a path through out_ready
    rdy_d = (state_d != FULL);
  end

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign rdy       = rdy_q;
  assign skid_data = sdata_q;
  assign skid_ctrl = sctrl_q;

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline-stage register with handshake, hold, flush
// Optional second (skid) entry with registered in_ready when PIPE_SKID_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 200,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              hold,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              push, pop;

  assign out_valid = vld_q & ~hold;
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & in_ready;
  assign out_data  = data_q;
  assign out_ctrl  = ctrl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      ctrl_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

`ifdef PIPE_SKID_EN
  logic              skid_rdy, ld_in, ld_skid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  pipe_skid_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .pop          (pop),
    .flush        (flush),
    .in_data      (in_data),
    .in_ctrl      (in_ctrl),
    .rdy          (skid_rdy),
    .main_ld_in   (ld_in),
    .main_ld_skid (ld_skid),
    .skid_data    (skid_data),
    .skid_ctrl    (skid_ctrl),
    .occupancy    (occupancy)
  );

  assign in_ready = skid_rdy & rst_n & ~hold & ~flush;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (flush) begin
      vld_d  = 1'b0;
      ctrl_d = '0;
    end else if (ld_skid) begin
      vld_d  = 1'b1;
      data_d = skid_data;
      ctrl_d = skid_ctrl;
    end else if (ld_in) begin
      vld_d  = 1'b1;
      data_d = in_data;
      ctrl_d = in_ctrl;
    end else if (pop) begin
      vld_d = 1'b0;
    end
  end
`else
  assign in_ready  = rst_n & (~vld_q | out_ready) & ~hold & ~flush;
  assign occupancy = {1'b0, vld_q};

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    ctrl_d = ctrl_q;
    // Flushed bubble keeps stale data but carries no memory or register-write side effects
    if (flush) begin
      vld_d  = 1'b0;
      ctrl_d = '0;
    end else if (push) begin
      vld_d  = 1'b1;
      data_d = in_data;
      ctrl_d = in_ctrl;
    end else if (pop) begin
      vld_d = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg (base or PIPE_SKID_EN build)
`timescale 1ns/1ps
module tb_pipe_stage_reg;

  localparam int DW = 200;
  localparam int CW = 5;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } item_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          hold = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    occupancy;

  item_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    n_pop = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .hold      (hold),
    .flush     (flush),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [223:0] t;
    for (int k = 0; k < 7; k++) t[k*32 +: 32] = $urandom;
    return t[DW-1:0];
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic h, input logic f);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    hold      = h;
    flush     = f;
    #1;
  endtask

  // Called 1ns after a falling edge: score this cycle's transfers, then advance one clock.
  task automatic clk_step();
    item_t e;
    if (out_valid && out_ready) begin
      check_eq("sb_nonempty_on_pop", 256'(sb.size() != 0), 256'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("pop_data", 256'(out_data), 256'(e.d));
        check_eq("pop_ctrl", 256'(out_ctrl), 256'(e.c));
      end
      n_pop++;
    end
    if (flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back('{d: in_data, c: in_ctrl});
    @(negedge clk);
  endtask

  logic [DW-1:0] dat [8];
  logic [CW-1:0] ctl [8];
  int            pops0;

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    check_eq("rst_in_ready", 256'(in_ready), 256'(0));
    check_eq("rst_out_valid", 256'(out_valid), 256'(0));
    check_eq("rst_occupancy", 256'(occupancy), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while a payload is held
    drive(1'b1, 200'hBEEF, 5'b11111, 1'b0, 1'b0, 1'b0);
    clk_step();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("pre_rst_valid", 256'(out_valid), 256'(1));
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 256'(out_valid), 256'(0));
    check_eq("midrst_out_ctrl", 256'(out_ctrl), 256'(0));
    check_eq("midrst_out_data", 256'(out_data), 256'(0));
    check_eq("midrst_occupancy", 256'(occupancy), 256'(0));
    check_eq("midrst_in_ready", 256'(in_ready), 256'(0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Streaming 8 payloads at full rate
    for (int i = 0; i < 8; i++) begin
      dat[i] = rnd_data();
      ctl[i] = CW'($urandom);
    end
    pops0 = n_pop;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(1'b1, dat[i], ctl[i], 1'b1, 1'b0, 1'b0);
      else       drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      check_eq("stream_in_ready", 256'(in_ready), 256'(1));
      check_eq("stream_out_valid", 256'(out_valid), 256'(i > 0));
      if (i > 0) check_eq("stream_latency", 256'(out_data), 256'(dat[i-1]));
      clk_step();
    end
    check_eq("stream_pop_count", 256'(n_pop - pops0), 256'(8));
    check_eq("stream_drained", 256'(sb.size()), 256'(0));

    // Hold freezes a valid payload
    drive(1'b1, 200'hA5, 5'b00101, 1'b0, 1'b0, 1'b0);
    clk_step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 200'h77, 5'b11111, 1'b1, 1'b1, 1'b0);
      check_eq("hold_out_valid", 256'(out_valid), 256'(0));
      check_eq("hold_in_ready", 256'(in_ready), 256'(0));
      check_eq("hold_out_data", 256'(out_data), 256'(200'hA5));
      clk_step();
    end
    pops0 = n_pop;
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("unhold_out_valid", 256'(out_valid), 256'(1));
    clk_step();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("unhold_once", 256'(out_valid), 256'(0));
    clk_step();
    check_eq("unhold_pop_count", 256'(n_pop - pops0), 256'(1));
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    clk_step();
    check_eq("idle_data_kept", 256'(out_data), 256'(200'hA5));
    check_eq("idle_ctrl_kept", 256'(out_ctrl), 256'(5'b00101));

    // Flush inserts a bubble
    drive(1'b1, 200'h33, 5'b11010, 1'b0, 1'b0, 1'b0);
    clk_step();
    drive(1'b1, 200'h99, 5'b11111, 1'b0, 1'b0, 1'b1);
    check_eq("flush_in_ready", 256'(in_ready), 256'(0));
    clk_step();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("flush_out_valid", 256'(out_valid), 256'(0));
    check_eq("flush_out_ctrl", 256'(out_ctrl), 256'(0));
    check_eq("flush_data_kept", 256'(out_data), 256'(200'h33));
    check_eq("flush_occupancy", 256'(occupancy), 256'(0));
    drive(1'b1, 200'h34, 5'b11010, 1'b0, 1'b0, 1'b0);
    clk_step();
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
    clk_step();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("flush_hold_valid", 256'(out_valid), 256'(0));
    check_eq("flush_hold_ctrl", 256'(out_ctrl), 256'(0));
    // Flush coinciding with a pop
    drive(1'b1, 200'h44, 5'b11010, 1'b0, 1'b0, 1'b0);
    clk_step();
    pops0 = n_pop;
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    check_eq("flush_pop_valid", 256'(out_valid), 256'(1));
    clk_step();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("flush_pop_count", 256'(n_pop - pops0), 256'(1));
    check_eq("flush_pop_after", 256'(out_valid), 256'(0));
    clk_step();

`ifdef PIPE_SKID_EN
    // Skid entry absorbs a second payload under back-pressure
    drive(1'b1, 200'h1, 5'b00001, 1'b0, 1'b0, 1'b0);
    check_eq("skid_rdy0", 256'(in_ready), 256'(1));
    clk_step();
    drive(1'b1, 200'h2, 5'b00010, 1'b0, 1'b0, 1'b0);
    check_eq("skid_rdy1", 256'(in_ready), 256'(1));
    clk_step();
    drive(1'b1, 200'h3, 5'b00011, 1'b0, 1'b0, 1'b0);
    check_eq("skid_full_occ", 256'(occupancy), 256'(2));
    check_eq("skid_full_rdy", 256'(in_ready), 256'(0));
    clk_step();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("skid_first", 256'(out_data), 256'(200'h1));
    clk_step();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("skid_second", 256'(out_data), 256'(200'h2));
    check_eq("skid_occ1", 256'(occupancy), 256'(1));
    clk_step();
    check_eq("skid_occ0", 256'(occupancy), 256'(0));
`else
    // Single-entry back-pressure, then push and pop in the same cycle
    drive(1'b1, 200'h1, 5'b00001, 1'b0, 1'b0, 1'b0);
    clk_step();
    drive(1'b1, 200'h2, 5'b00010, 1'b0, 1'b0, 1'b0);
    check_eq("bp_in_ready", 256'(in_ready), 256'(0));
    check_eq("bp_occupancy", 256'(occupancy), 256'(1));
    clk_step();
    drive(1'b1, 200'h2, 5'b00010, 1'b1, 1'b0, 1'b0);
    check_eq("pp_in_ready", 256'(in_ready), 256'(1));
    check_eq("pp_out_valid", 256'(out_valid), 256'(1));
    clk_step();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("pp_next_data", 256'(out_data), 256'(200'h2));
    check_eq("pp_occupancy", 256'(occupancy), 256'(1));
    clk_step();
`endif

    // Random traffic with occasional hold and flush
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), rnd_data(), CW'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0));
      clk_step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      clk_step();
    end
    check_eq("random_drained", 256'(sb.size()), 256'(0));
    check_eq("random_idle_valid", 256'(out_valid), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
